// File: rtl/cabac_feeder_pkg.sv
// Shared constants and helpers for the CABAC byte feeder.
package cabac_feeder_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_MAX_RD = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // DEPTH is a power of two, so masking is enough to wrap the lane index
  function automatic int lane_ptr(input int rd_ptr, input int k, input int depth);
    return (rd_ptr + k) & (depth - 1);
  endfunction

endpackage

// File: rtl/cabac_byte_feeder.sv
// Circular byte FIFO with show-ahead head lanes feeding the arithmetic decoder.
// Consumes 0..MAX_RD bytes per cycle; flush, sticky underflow and consumed-byte count.
module cabac_byte_feeder
  import cabac_feeder_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int MAX_RD = DEFAULT_MAX_RD,
  parameter int CNT_W  = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [BYTE_W-1:0]                 in_data,
  output logic                              in_ready,
  input  logic                              pop,
  input  logic [clog2(MAX_RD+1)-1:0]        pop_cnt,
  input  logic                              flush,
  output logic [BYTE_W*MAX_RD-1:0]          out_data,
  output logic [clog2(MAX_RD+1)-1:0]        out_avail,
  output logic [clog2(DEPTH):0]             level,
  output logic                              underflow,
  output logic [CNT_W-1:0]                  consumed
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int LVL_W  = clog2(DEPTH) + 1;
  localparam int POPC_W = clog2(MAX_RD + 1);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push_ok;
  logic              pop_req;
  logic              pop_bad;
  logic              pop_ok;

  // in_ready depends only on the registered level, never on this cycle's pop
  assign in_ready = (level < LVL_W'(DEPTH));
  assign push_ok  = in_valid & in_ready;
  assign pop_req  = pop & (pop_cnt != '0);
  assign pop_bad  = pop_req & ((pop_cnt > POPC_W'(MAX_RD)) | (LVL_W'(pop_cnt) > level));
  assign pop_ok   = pop_req & ~pop_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      consumed  <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      consumed  <= '0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + PTR_W'(pop_cnt);
        consumed <= consumed + CNT_W'(pop_cnt);
      end
      if (pop_bad) underflow <= 1'b1;
      level <= level + LVL_W'(push_ok) - (pop_ok ? LVL_W'(pop_cnt) : LVL_W'(0));
    end
  end

  // Storage needs no reset; unused lanes are masked by level below
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= in_data;
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < MAX_RD; k++) begin
      if (LVL_W'(k) < level)
        out_data[k*BYTE_W +: BYTE_W] = mem[PTR_W'(lane_ptr(int'(rd_ptr), k, DEPTH))];
    end
  end

  assign out_avail = (level >= LVL_W'(MAX_RD)) ? POPC_W'(MAX_RD) : POPC_W'(level);

endmodule

// File: tb/tb_cabac_byte_feeder.sv
// Directed bench for cabac_byte_feeder (DEPTH=8, MAX_RD=2) with hand-computed expectations.
module tb_cabac_byte_feeder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        pop;
  logic [1:0]  pop_cnt;
  logic        flush;
  logic [15:0] out_data;
  logic [1:0]  out_avail;
  logic [3:0]  level;
  logic        underflow;
  logic [31:0] consumed;

  int n_chk  = 0;
  int n_fail = 0;

  cabac_byte_feeder #(.DEPTH(8), .MAX_RD(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pop(pop), .pop_cnt(pop_cnt), .flush(flush), .out_data(out_data), .out_avail(out_avail),
    .level(level), .underflow(underflow), .consumed(consumed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; pop = 1'b0; pop_cnt = 2'd0; flush = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    idle(); in_valid = 1'b1; in_data = d; tick(); idle();
  endtask

  task automatic pop_n(input logic [1:0] n);
    idle(); pop = 1'b1; pop_cnt = n; tick(); idle();
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; tick(); idle();
  endtask

  initial begin
    reset = 1'b0; in_data = 8'h00; idle();
    #12;
    chk("rst_level", level, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_avail", out_avail, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_consumed", consumed, 0);
    chk("post_rst_underflow", underflow, 0);

    // fill to full, then offer a 9th byte
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("full_level", level, 8);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_data", out_data, 16'h1110);
    chk("full_out_avail", out_avail, 2);
    push(8'h18);
    chk("ninth_level", level, 8);
    pop_n(2); chk("drain1", out_data, 16'h1312);
    pop_n(2); chk("drain2", out_data, 16'h1514);
    pop_n(2); chk("drain3", out_data, 16'h1716);
    pop_n(2);
    chk("drain_empty_level", level, 0);
    chk("drain_empty_data", out_data, 0);
    chk("drain_consumed", consumed, 8);

    // mixed pops across the pointer wrap
    do_flush();
    for (int i = 0; i < 8; i++) push(8'(i));
    pop_n(2); chk("mix_pop2", out_data, 16'h0302);
    pop_n(1); chk("mix_pop1", out_data, 16'h0403);
    pop_n(2); chk("mix_pop2b", out_data, 16'h0605);
    chk("mix_level3", level, 3);
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    chk("mix_consumed", consumed, 5);
    chk("mix_level8", level, 8);
    chk("mix_head", out_data, 16'h0605);
    pop_n(1); chk("wrap_a", out_data, 16'h0706);
    pop_n(1); chk("wrap_b", out_data, 16'hA007);
    pop_n(2); chk("wrap_c", out_data, 16'hA2A1);
    chk("wrap_level", level, 4);
    chk("wrap_consumed", consumed, 9);

    // simultaneous push and pop 2 at level 3
    do_flush();
    push(8'h30); push(8'h31); push(8'h32);
    in_valid = 1'b1; in_data = 8'h33; pop = 1'b1; pop_cnt = 2'd2;
    tick(); idle();
    chk("pp_level", level, 2);
    chk("pp_out_data", out_data, 16'h3332);
    chk("pp_consumed", consumed, 2);

    // illegal pop with concurrent push
    pop_n(1);
    chk("ill_pre_level", level, 1);
    chk("ill_pre_avail", out_avail, 1);
    chk("ill_pre_data", out_data, 16'h0033);
    in_valid = 1'b1; in_data = 8'h44; pop = 1'b1; pop_cnt = 2'd2;
    tick(); idle();
    chk("ill_level", level, 2);
    chk("ill_consumed", consumed, 3);
    chk("ill_underflow", underflow, 1);
    chk("ill_out_data", out_data, 16'h4433);
    tick();
    chk("ill_sticky", underflow, 1);
    pop_n(3);
    chk("ill_gt_max_level", level, 2);
    chk("ill_gt_max_consumed", consumed, 3);
    pop_n(0);
    chk("pop0_level", level, 2);
    do_flush();
    chk("flush_underflow", underflow, 0);
    chk("flush_level", level, 0);
    chk("flush_consumed", consumed, 0);

    // flush with concurrent push and pop at level 4
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h54; pop = 1'b1; pop_cnt = 2'd1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    tick(); idle();
    chk("fcp_level", level, 0);
    chk("fcp_avail", out_avail, 0);
    chk("fcp_data", out_data, 0);
    push(8'h60);
    chk("after_flush_data", out_data, 16'h0060);
    chk("after_flush_level", level, 1);

    // asynchronous reset mid-stream at level 5
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    chk("pre_rst_level", level, 5);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_avail", out_avail, 0);
    chk("mid_rst_consumed", consumed, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_level", level, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
